// File: rtl/rvsoc_mem_pkg.sv
// Shared definitions for the core data-memory path: funct3 load/store encodings,
// bridge FSM states and the lane/select helpers used when launching a bus cycle.
package rvsoc_mem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned TMO_W = 16;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } bridge_state_e;

    // Unsigned variants only exist for loads; stores accept B/H/W only.
    function automatic logic op_illegal(input logic is_store, input logic [2:0] op);
        logic bad;
        case (op)
            MEM_B, MEM_H, MEM_W: bad = 1'b0;
            MEM_BU, MEM_HU:      bad = is_store;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic op_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [SEL_W-1:0] lane_sel(input logic [1:0] size, input logic [1:0] lane);
        logic [SEL_W-1:0] sel;
        case (size)
            2'b00:   sel = 4'b0001 << lane;
            2'b01:   sel = lane[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // Replicating the store data across lanes lets the slave pick any lane via sel.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] dat;
        case (size)
            2'b00:   dat = {4{wdata[7:0]}};
            2'b01:   dat = {2{wdata[15:0]}};
            default: dat = wdata;
        endcase
        return dat;
    endfunction

endpackage

// File: rtl/core_wb_bridge_if.sv
// Wishbone B4 classic single-master bundle between the core bridge and the SoC
// interconnect. Names keep the master-side _o/_i view of the bus.
interface core_wb_bridge_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i;
    logic              wb_we_o;
    logic [3:0]        wb_sel_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/load_align_unit.sv
// Extracts the addressed byte/half from a 32-bit read word and sign- or
// zero-extends it according to the load funct3. Purely combinational.
module load_align_unit
    import rvsoc_mem_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      op,
    input  logic [1:0]      lane,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction for byte and halfword accesses.
    always_comb begin
        byte_s = 8'h00;
        case (lane)
            2'd0:    byte_s = raw[7:0];
            2'd1:    byte_s = raw[15:8];
            2'd2:    byte_s = raw[23:16];
            2'd3:    byte_s = raw[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = raw[31:16];
        end else begin
            half_s = raw[15:0];
        end
    end

    // Sign/zero extension selected by funct3.
    always_comb begin
        data = 32'h0000_0000;
        case (op)
            MEM_B:   data = {{24{byte_s[7]}}, byte_s};
            MEM_BU:  data = {24'h00_0000, byte_s};
            MEM_H:   data = {{16{half_s[15]}}, half_s};
            MEM_HU:  data = {16'h0000, half_s};
            MEM_W:   data = raw;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/core_wb_bridge.sv
// MEM-stage responder: turns one core load/store into one Wishbone classic
// single-beat cycle, stalls the pipeline meanwhile and returns aligned load data.
module core_wb_bridge
    import rvsoc_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] mem_addr_mem,
    input  logic [31:0]       mem_wdata_mem,
    input  logic              mem_write_mem,
    input  logic              mem_read_mem,
    input  logic [2:0]        mem_op_mem,
    output logic [31:0]       mem_rdata_mem,
    output logic              stall_pipl,
    core_wb_bridge_if.master  wb,
    output logic              bus_err_o,
    output logic              align_err_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);

    bridge_state_e     state_r;
    bridge_state_e     state_nxt_s;

    logic              req_s;
    logic              reject_s;
    logic              fault_s;
    logic              tmo_hit_s;

    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [SEL_W-1:0]  sel_r;
    logic              we_r;
    logic [2:0]        op_r;
    logic [TMO_W-1:0]  tmo_cnt_r;

    logic [31:0]       rdata_r;
    logic              bus_err_r;
    logic              align_err_r;
    logic [31:0]       align_data_s;

    // Write wins when the core raises both strobes, so the store check drives legality.
    assign req_s     = mem_read_mem | mem_write_mem;
    assign reject_s  = op_illegal(mem_write_mem, mem_op_mem)
                     | op_misaligned(mem_op_mem[1:0], mem_addr_mem[1:0]);
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
    assign fault_s   = wb.wb_err_i | tmo_hit_s;

    load_align_unit u_align (
        .raw  (wb.wb_dat_i),
        .op   (op_r),
        .lane (addr_r[1:0]),
        .data (align_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; DONE never relaunches the request still visible on the port.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = reject_s ? ST_DONE : ST_BUS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (fault_s || wb.wb_ack_i) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUS;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: bus fields are only presented while a cycle is open.
    always_comb begin
        stall_pipl  = 1'b0;
        wb.wb_cyc_o = 1'b0;
        wb.wb_stb_o = 1'b0;
        wb.wb_adr_o = '0;
        wb.wb_dat_o = 32'h0000_0000;
        wb.wb_we_o  = 1'b0;
        wb.wb_sel_o = 4'b0000;
        case (state_r)
            ST_IDLE: stall_pipl = req_s;
            ST_BUS: begin
                stall_pipl  = 1'b1;
                wb.wb_cyc_o = 1'b1;
                wb.wb_stb_o = 1'b1;
                wb.wb_adr_o = {addr_r[ADDR_W-1:2], 2'b00};
                wb.wb_dat_o = wdata_r;
                wb.wb_we_o  = we_r;
                wb.wb_sel_o = sel_r;
            end
            ST_DONE: stall_pipl = 1'b0;
            default: stall_pipl = 1'b0;
        endcase
    end

    // Request capture on the IDLE->BUS edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            sel_r   <= 4'b0000;
            we_r    <= 1'b0;
            op_r    <= 3'b000;
        end else if (state_r == ST_IDLE && req_s && !reject_s) begin
            addr_r  <= mem_addr_mem;
            wdata_r <= lane_wdata(mem_op_mem[1:0], mem_wdata_mem);
            sel_r   <= lane_sel(mem_op_mem[1:0], mem_addr_mem[1:0]);
            we_r    <= mem_write_mem;
            op_r    <= mem_op_mem;
        end
    end

    // Cycles spent in BUS; cleared whenever the cycle closes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_BUS && state_nxt_s == ST_BUS) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Load data and error pulses, all valid during the single DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r     <= 32'h0000_0000;
            bus_err_r   <= 1'b0;
            align_err_r <= 1'b0;
        end else begin
            bus_err_r   <= 1'b0;
            align_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s && reject_s) begin
                        align_err_r <= 1'b1;
                        if (!mem_write_mem) begin
                            rdata_r <= 32'h0000_0000;
                        end
                    end
                end
                ST_BUS: begin
                    if (fault_s) begin
                        bus_err_r <= 1'b1;
                        if (!we_r) begin
                            rdata_r <= 32'h0000_0000;
                        end
                    end else if (wb.wb_ack_i && !we_r) begin
                        rdata_r <= align_data_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rdata_mem = rdata_r;
    assign bus_err_o     = bus_err_r;
    assign align_err_o   = align_err_r;

endmodule

// File: tb/tb_core_wb_bridge.sv
// Scoreboard bench for core_wb_bridge: the driver queues the hand-computed response
// of each access, a monitor pops it when the access completes (stall falls).
module tb_core_wb_bridge;
    import rvsoc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr_mem;
    logic [31:0] mem_wdata_mem;
    logic        mem_write_mem;
    logic        mem_read_mem;
    logic [2:0]  mem_op_mem;
    logic [31:0] mem_rdata_mem;
    logic        stall_pipl;
    logic        bus_err_o;
    logic        align_err_o;

    core_wb_bridge_if #(.ADDR_W(32)) wb ();

    core_wb_bridge #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr_mem  (mem_addr_mem),
        .mem_wdata_mem (mem_wdata_mem),
        .mem_write_mem (mem_write_mem),
        .mem_read_mem  (mem_read_mem),
        .mem_op_mem    (mem_op_mem),
        .mem_rdata_mem (mem_rdata_mem),
        .stall_pipl    (stall_pipl),
        .wb            (wb),
        .bus_err_o     (bus_err_o),
        .align_err_o   (align_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
        int          cyc;
        int          stall;
        logic        berr;
        logic        aerr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = 32'h0;
    int          slv_waits = 0;
    int          slv_err_at = 0;
    logic [31:0] slv_dat = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Wishbone slave: acks after slv_waits wait states, or errors in cycle slv_err_at.
    initial begin : slave
        int cnt;
        cnt = 0;
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        wb.wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (wb.wb_cyc_o && wb.wb_stb_o) begin
                cnt++;
                wb.wb_dat_i = slv_dat;
                wb.wb_err_i = (slv_err_at != 0) && (cnt == slv_err_at);
                wb.wb_ack_i = (slv_err_at == 0) && (cnt > slv_waits);
            end else begin
                cnt = 0;
                wb.wb_ack_i = 1'b0;
                wb.wb_err_i = 1'b0;
                wb.wb_dat_i = 32'h0;
            end
        end
    end

    // Monitor: observes each access and checks it against the queued expectation.
    initial begin : monitor
        logic        prev_stall;
        int          cyc_n;
        int          stall_n;
        logic [31:0] m_adr;
        logic [31:0] m_dat;
        logic [3:0]  m_sel;
        logic        m_we;
        exp_t        e;
        prev_stall = 1'b0;
        cyc_n = 0;
        stall_n = 0;
        m_adr = 32'h0; m_dat = 32'h0; m_sel = 4'h0; m_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
                cyc_n = 0;
                stall_n = 0;
            end else begin
                if (wb.wb_cyc_o) begin
                    if (cyc_n == 0) begin
                        m_adr = wb.wb_adr_o; m_dat = wb.wb_dat_o;
                        m_sel = wb.wb_sel_o; m_we = wb.wb_we_o;
                    end
                    cyc_n++;
                end
                if (stall_pipl) begin
                    stall_n++;
                end else if (prev_stall) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got completion, want none queued");
                    end else begin
                        e = sb_q.pop_front();
                        chk("rdata", mem_rdata_mem, e.rdata);
                        chk("bus_err", {31'h0, bus_err_o}, {31'h0, e.berr});
                        chk("align_err", {31'h0, align_err_o}, {31'h0, e.aerr});
                        chk("cyc_cycles", cyc_n, e.cyc);
                        chk("stall_cycles", stall_n, e.stall);
                        if (e.cyc > 0) begin
                            chk("wb_adr", m_adr, e.adr);
                            chk("wb_sel", {28'h0, m_sel}, {28'h0, e.sel});
                            chk("wb_we", {31'h0, m_we}, {31'h0, e.we});
                            if (e.we) chk("wb_dat", m_dat, e.dat);
                        end
                    end
                    cyc_n = 0;
                    stall_n = 0;
                end
                prev_stall = stall_pipl;
            end
        end
    end

    task automatic issue(input logic w, input logic r, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input int err_at, input logic [31:0] sdat,
                         input logic [31:0] exp_ld, input logic [3:0] exp_sel,
                         input logic [31:0] exp_dat, input int exp_cyc,
                         input logic berr, input logic aerr);
        exp_t e;
        bit   done;
        e.rdata = w ? model_rdata : exp_ld;
        model_rdata = e.rdata;
        e.adr = {addr[31:2], 2'b00};
        e.sel = exp_sel;
        e.dat = exp_dat;
        e.we = w;
        e.cyc = exp_cyc;
        e.stall = (exp_cyc == 0) ? 1 : exp_cyc + 1;
        e.berr = berr;
        e.aerr = aerr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        slv_waits = waits; slv_err_at = err_at; slv_dat = sdat;
        mem_write_mem = w; mem_read_mem = r; mem_op_mem = op;
        mem_addr_mem = addr; mem_wdata_mem = wdata;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall_pipl) done = 1'b1;
        end
        chk("access_done", {31'h0, done}, 32'h1);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        mem_write_mem = 1'b0;
        mem_read_mem = 1'b0;
    endtask

    initial begin : driver
        reset_n = 1'b0;
        mem_addr_mem = 32'h0; mem_wdata_mem = 32'h0;
        mem_write_mem = 1'b0; mem_read_mem = 1'b0; mem_op_mem = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, stall_pipl}, 32'h0);
        chk("rst_wb_ctl", {26'h0, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o[2:0]}, 32'h0);
        chk("rst_wb_sel", {28'h0, wb.wb_sel_o}, 32'h0);
        chk("rst_wb_adr", wb.wb_adr_o, 32'h0);
        chk("rst_wb_dat", wb.wb_dat_o, 32'h0);
        chk("rst_rdata", mem_rdata_mem, 32'h0);
        chk("rst_errs", {30'h0, bus_err_o, align_err_o}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        //    w     r     op      addr          wdata         wt    err sdat          exp_ld        sel    dat           cyc berr aerr
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0,        2,    0, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 32'h0,        3, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0,        0,    0, 32'h80FF0000, 32'hFFFFFF80, 4'h8, 32'h0,        1, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b100, 32'h0000_0013, 32'h0,        1,    0, 32'h80FF0000, 32'h00000080, 4'h8, 32'h0,        2, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0,        0,    0, 32'h80FF0000, 32'hFFFF80FF, 4'hC, 32'h0,        1, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b101, 32'h0000_0012, 32'h0,        0,    0, 32'h80FF0000, 32'h000080FF, 4'hC, 32'h0,        1, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0021, 32'h123456AB, 0,    0, 32'h0,        32'h0,        4'h2, 32'hABABABAB, 1, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0000BEEF, 1,    0, 32'h0,        32'h0,        4'hC, 32'hBEEFBEEF, 2, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0003, 32'h0,        0,    0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0,        0,    0, 32'h11223344, 32'h11223344, 4'hF, 32'h0,        1, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b011, 32'h0000_0010, 32'h0,        0,    0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h0,        0,    0, 32'h55667788, 32'h55667788, 4'hF, 32'h0,        1, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0018, 32'h0,        1000, 0, 32'h0,        32'h0,        4'hF, 32'h0,        8, 1'b1, 1'b0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_001C, 32'h0,        0,    0, 32'h99AABBCC, 32'h99AABBCC, 4'hF, 32'h0,        1, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0011, 32'h0,        0,    0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0024, 32'h0,        0,    0, 32'h0BADF00D, 32'h0BADF00D, 4'hF, 32'h0,        1, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h0,        1000, 2, 32'h0,        32'h0,        4'hF, 32'h0,        2, 1'b1, 1'b0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0028, 32'h0,        0,    0, 32'h13572468, 32'h13572468, 4'hF, 32'h0,        1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 3'b010, 32'h0000_0030, 32'hCAFEF00D, 0,    0, 32'h0,        32'h0,        4'hF, 32'hCAFEF00D, 1, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0030, 32'h0,        0,    0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1'b0, 1'b1);

        // Reset while a load waits in BUS on a silent slave.
        @(posedge clk);
        #1;
        slv_waits = 1000; slv_err_at = 0;
        mem_read_mem = 1'b1; mem_write_mem = 1'b0; mem_op_mem = 3'b010;
        mem_addr_mem = 32'h0000_0040;
        repeat (3) @(negedge clk);
        chk("pre_rst_cyc", {31'h0, wb.wb_cyc_o}, 32'h1);
        #2;
        mem_read_mem = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_cyc_stb", {30'h0, wb.wb_cyc_o, wb.wb_stb_o}, 32'h0);
        chk("async_rst_stall", {31'h0, stall_pipl}, 32'h0);
        chk("async_rst_rdata", mem_rdata_mem, 32'h0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        model_rdata = 32'h0;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'h0,        1,    0, 32'hA5A55A5A, 32'hA5A55A5A, 4'hF, 32'h0,        2, 1'b0, 1'b0);
        go_idle();
        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
